// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Latches the execute payload, waits for the data-SRAM load response, and
// extracts/extends the addressed byte or halfword before handing off.
// Optional feature macro: MS_SUBWORD_LOAD_EN enables byte/halfword
// extraction; without it every load returns the full response word.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  output logic        ms_allow_in,
  input  logic        es_to_ms_valid,
  input  logic [73:0] es_ms_bus,
  input  logic        ws_allow_in,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_ws_bus,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic [37:0] ms_fwd_bus,
  output logic        ms_load_pending
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned LOADOP_W = 3;

  // Layout of the execute-to-memory payload, MSB first.
  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic                gr_we;
    logic [REG_AW-1:0]   dest;
    logic [XLEN-1:0]     alu_result;
    logic                res_from_mem;
    logic [LOADOP_W-1:0] load_op;
  } es_ms_payload_t;

  localparam logic [LOADOP_W-1:0] LD_B  = 3'b001;
  localparam logic [LOADOP_W-1:0] LD_H  = 3'b010;
  localparam logic [LOADOP_W-1:0] LD_BU = 3'b101;
  localparam logic [LOADOP_W-1:0] LD_HU = 3'b110;

  logic            ms_valid;
  es_ms_payload_t  payload;
  logic            buf_valid;
  logic [XLEN-1:0] rdata_buf;

  logic            ms_ready_go;
  logic            handoff;
  logic            buf_capture;
  logic [XLEN-1:0] load_word;
  logic [XLEN-1:0] load_result;
  logic [XLEN-1:0] final_result;

  // Handshake: loads wait for either a live response or a buffered one.
  always_comb begin
    ms_ready_go     = !payload.res_from_mem || data_sram_data_ok || buf_valid;
    ms_allow_in     = !ms_valid || (ms_ready_go && ws_allow_in);
    ms_to_ws_valid  = ms_valid && ms_ready_go;
    ms_load_pending = ms_valid && payload.res_from_mem && !ms_ready_go;
    handoff         = ms_to_ws_valid && ws_allow_in;
    buf_capture     = ms_valid && payload.res_from_mem && data_sram_data_ok &&
                      !ws_allow_in && !buf_valid;
  end

  // Valid bit and payload; payload only moves when a new instruction enters.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
      payload  <= '0;
    end else begin
      if (ms_allow_in) begin
        ms_valid <= es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allow_in) begin
        payload <= es_ms_payload_t'(es_ms_bus);
      end
    end
  end

  // Response buffer holds a load word while write-back is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      rdata_buf <= '0;
    end else if (handoff) begin
      buf_valid <= 1'b0;
    end else if (buf_capture) begin
      buf_valid <= 1'b1;
      rdata_buf <= data_sram_rdata;
    end
  end

  // Buffered word wins; a late data_ok while buffered is ignored.
  always_comb begin
    load_word = buf_valid ? rdata_buf : data_sram_rdata;
  end

`ifdef MS_SUBWORD_LOAD_EN
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Byte lane by addr[1:0]; halfword by addr[1] only.
  always_comb begin
    sel_byte = 8'h00;
    case (payload.alu_result[1:0])
      2'b00:   sel_byte = load_word[7:0];
      2'b01:   sel_byte = load_word[15:8];
      2'b10:   sel_byte = load_word[23:16];
      default: sel_byte = load_word[31:24];
    endcase
    sel_half = payload.alu_result[1] ? load_word[31:16] : load_word[15:0];
  end

  // Sign/zero extension per load opcode; unknown codes act as ld.w.
  always_comb begin
    load_result = load_word;
    case (payload.load_op)
      LD_B:    load_result = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      LD_H:    load_result = {{(XLEN-16){sel_half[15]}}, sel_half};
      LD_BU:   load_result = {(XLEN-8)'(0), sel_byte};
      LD_HU:   load_result = {(XLEN-16)'(0), sel_half};
      default: load_result = load_word;
    endcase
  end
`else
  logic unused_subword;

  // Full-word loads only; the opcode and lane constants are not consulted.
  always_comb begin
    load_result    = load_word;
    unused_subword = ^{payload.load_op, LD_B, LD_H, LD_BU, LD_HU};
  end
`endif

  // Result mux and outgoing buses.
  always_comb begin
    final_result = payload.res_from_mem ? load_result : payload.alu_result;
    ms_ws_bus    = {payload.pc, payload.gr_we, payload.dest, final_result};
    ms_fwd_bus   = {payload.gr_we && ms_valid, payload.dest, final_result};
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ms_allow_in;
  logic        es_to_ms_valid;
  logic [73:0] es_ms_bus;
  logic        ws_allow_in;
  logic        ms_to_ws_valid;
  logic [69:0] ms_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [37:0] ms_fwd_bus;
  logic        ms_load_pending;

  int total;
  int bad;

`ifdef MS_SUBWORD_LOAD_EN
  localparam logic [31:0] EXP_LDB  = 32'hFFFF_FF80;
  localparam logic [31:0] EXP_LDBU = 32'h0000_0080;
  localparam logic [31:0] EXP_LDHU = 32'h0000_BEEF;
`else
  localparam logic [31:0] EXP_LDB  = 32'h80FF_0000;
  localparam logic [31:0] EXP_LDBU = 32'h80FF_0000;
  localparam logic [31:0] EXP_LDHU = 32'hBEEF_0001;
`endif

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_allow_in       (ms_allow_in),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_ms_bus         (es_ms_bus),
    .ws_allow_in       (ws_allow_in),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_ws_bus         (ms_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_fwd_bus        (ms_fwd_bus),
    .ms_load_pending   (ms_load_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [73:0] mk_es(input logic [31:0] pc, input logic we,
                                        input logic [4:0] dest, input logic [31:0] alu,
                                        input logic rfm, input logic [2:0] op);
    return {pc, we, dest, alu, rfm, op};
  endfunction

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset             = 1'b1;
    es_to_ms_valid    = 1'b1;
    es_ms_bus         = mk_es(32'h1c00_00aa, 1'b1, 5'd3, 32'h0000_5555, 1'b0, 3'b000);
    ws_allow_in       = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;

    // Reset held two cycles with a valid offer pending.
    for (int i = 0; i < 2; i++) begin
      tick();
      settle();
      check("rst_to_ws_valid", 70'(ms_to_ws_valid), 70'(0));
      check("rst_ws_bus", ms_ws_bus, 70'(0));
      check("rst_allow_in", 70'(ms_allow_in), 70'(1));
      check("rst_fwd_bus", 70'(ms_fwd_bus), 70'(0));
      check("rst_pending", 70'(ms_load_pending), 70'(0));
    end

    // ALU op offered right after release.
    reset     = 1'b0;
    es_ms_bus = mk_es(32'h1c00_0000, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 3'b000);
    settle();
    check("alu_allow_in_empty", 70'(ms_allow_in), 70'(1));
    tick();
    es_to_ms_valid = 1'b0;
    settle();
    check("alu_to_ws_valid", 70'(ms_to_ws_valid), 70'(1));
    check("alu_ws_bus", ms_ws_bus, {32'h1c00_0000, 1'b1, 5'd5, 32'h0000_1234});
    check("alu_fwd_bus", 70'(ms_fwd_bus), 70'({1'b1, 5'd5, 32'h0000_1234}));
    check("alu_pending", 70'(ms_load_pending), 70'(0));
    check("alu_allow_in", 70'(ms_allow_in), 70'(1));
    tick();
    settle();
    check("alu_drained_valid", 70'(ms_to_ws_valid), 70'(0));
    check("alu_drained_fwd", 70'(ms_fwd_bus), 70'({1'b0, 5'd5, 32'h0000_1234}));

    // ld.b at byte 3, response three cycles after entry.
    es_to_ms_valid = 1'b1;
    es_ms_bus      = mk_es(32'h1c00_0004, 1'b1, 5'd6, 32'h0000_1003, 1'b1, 3'b001);
    tick();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("ldb_pending", 70'(ms_load_pending), 70'(1));
      check("ldb_wait_valid", 70'(ms_to_ws_valid), 70'(0));
      check("ldb_wait_allow", 70'(ms_allow_in), 70'(0));
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_0000;
    settle();
    check("ldb_pending_done", 70'(ms_load_pending), 70'(0));
    check("ldb_valid", 70'(ms_to_ws_valid), 70'(1));
    check("ldb_ws_bus", ms_ws_bus, {32'h1c00_0004, 1'b1, 5'd6, EXP_LDB});
    tick();
    data_sram_data_ok = 1'b0;

    // ld.bu, same address and data, response one cycle after entry.
    es_to_ms_valid = 1'b1;
    es_ms_bus      = mk_es(32'h1c00_0008, 1'b1, 5'd6, 32'h0000_1003, 1'b1, 3'b101);
    settle();
    check("ldbu_allow_empty", 70'(ms_allow_in), 70'(1));
    tick();
    es_to_ms_valid = 1'b0;
    settle();
    check("ldbu_pending", 70'(ms_load_pending), 70'(1));
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_0000;
    settle();
    check("ldbu_result", 70'(ms_ws_bus[31:0]), 70'(EXP_LDBU));
    tick();
    data_sram_data_ok = 1'b0;

    // ld.hu upper half, response while write-back stalled for four cycles.
    es_to_ms_valid = 1'b1;
    es_ms_bus      = mk_es(32'h1c00_000c, 1'b1, 5'd7, 32'h0000_2002, 1'b1, 3'b110);
    tick();
    es_to_ms_valid    = 1'b0;
    ws_allow_in       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBEEF_0001;
    settle();
    check("ldhu_valid_live", 70'(ms_to_ws_valid), 70'(1));
    check("ldhu_allow_stall", 70'(ms_allow_in), 70'(0));
    check("ldhu_live_result", 70'(ms_ws_bus[31:0]), 70'(EXP_LDHU));
    for (int i = 0; i < 3; i++) begin
      tick();
      data_sram_data_ok = (i == 1);
      data_sram_rdata   = 32'h0;
      settle();
      check("ldhu_buf_valid", 70'(ms_to_ws_valid), 70'(1));
      check("ldhu_buf_pending", 70'(ms_load_pending), 70'(0));
      check("ldhu_buf_bus", ms_ws_bus, {32'h1c00_000c, 1'b1, 5'd7, EXP_LDHU});
    end
    // Release write-back while a ld.w enters in the same cycle.
    tick();
    data_sram_data_ok = 1'b0;
    ws_allow_in       = 1'b1;
    es_to_ms_valid    = 1'b1;
    es_ms_bus         = mk_es(32'h1c00_0010, 1'b1, 5'd11, 32'h0000_5000, 1'b1, 3'b000);
    settle();
    check("ldhu_release_result", 70'(ms_ws_bus[31:0]), 70'(EXP_LDHU));
    check("ldhu_release_allow", 70'(ms_allow_in), 70'(1));
    tick();
    es_to_ms_valid = 1'b0;
    settle();
    check("ldw_after_buf_pending", 70'(ms_load_pending), 70'(1));
    check("ldw_after_buf_valid", 70'(ms_to_ws_valid), 70'(0));
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h55AA_55AA;
    settle();
    check("ldw_after_buf_bus", ms_ws_bus, {32'h1c00_0010, 1'b1, 5'd11, 32'h55AA_55AA});
    tick();
    data_sram_data_ok = 1'b0;

    // Back-to-back: load with response on its first cycle, then ALU op.
    es_to_ms_valid = 1'b1;
    es_ms_bus      = mk_es(32'h1c00_0014, 1'b1, 5'd8, 32'h0000_3000, 1'b1, 3'b000);
    tick();
    es_ms_bus         = mk_es(32'h1c00_0018, 1'b1, 5'd9, 32'h0000_CAFE, 1'b0, 3'b000);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1122_3344;
    settle();
    check("b2b_load_valid", 70'(ms_to_ws_valid), 70'(1));
    check("b2b_allow_in", 70'(ms_allow_in), 70'(1));
    check("b2b_load_bus", ms_ws_bus, {32'h1c00_0014, 1'b1, 5'd8, 32'h1122_3344});
    tick();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b0;
    settle();
    check("b2b_alu_valid", 70'(ms_to_ws_valid), 70'(1));
    check("b2b_alu_bus", ms_ws_bus, {32'h1c00_0018, 1'b1, 5'd9, 32'h0000_CAFE});
    tick();

    // Reset while a load waits; data_ok in the reset cycle is dropped.
    es_to_ms_valid = 1'b1;
    es_ms_bus      = mk_es(32'h1c00_001c, 1'b1, 5'd10, 32'h0000_4000, 1'b1, 3'b000);
    tick();
    es_to_ms_valid = 1'b0;
    settle();
    check("rst_load_pending", 70'(ms_load_pending), 70'(1));
    reset             = 1'b1;
    ws_allow_in       = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_DEAD;
    tick();
    reset = 1'b0;
    settle();
    check("rst_mid_valid", 70'(ms_to_ws_valid), 70'(0));
    check("rst_mid_pending", 70'(ms_load_pending), 70'(0));
    check("rst_mid_allow", 70'(ms_allow_in), 70'(1));
    check("rst_mid_bus", ms_ws_bus, 70'(0));
    tick();
    data_sram_data_ok = 1'b0;
    ws_allow_in       = 1'b1;
    settle();
    check("rst_stray_valid", 70'(ms_to_ws_valid), 70'(0));
    check("rst_stray_fwd", 70'(ms_fwd_bus), 70'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
